// File: rtl/keccak_pkg.sv
// Shared Keccak slice-serial definitions: geometry, FSM/shifter encodings and
// the rho lane schedule used by both the forward and inverse rotate datapaths.
package keccak_pkg;

    localparam int SLICES   = 64;
    localparam int LANES    = 25;
    localparam int ROUNDS_T = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RD,
        ST_ROT,
        ST_WR,
        ST_OUT
    } state_t;

    typedef enum logic [1:0] {
        SH_HOLD,
        SH_SHIFT_IN,
        SH_ROT_RIGHT
    } shift_op_t;

    // Lane x+5y visited at step t, walking (x,y)->(y,(2x+3y) mod 5) from (1,0).
    localparam logic [4:0] LANE_TABLE [ROUNDS_T] = '{
        5'd1,  5'd10, 5'd7,  5'd11, 5'd17, 5'd18, 5'd3,  5'd5,
        5'd16, 5'd8,  5'd21, 5'd24, 5'd4,  5'd15, 5'd23, 5'd19,
        5'd13, 5'd12, 5'd2,  5'd20, 5'd14, 5'd22, 5'd9,  5'd6
    };

    // Rho offset of the lane at step t, already reduced mod 64; never zero.
    localparam logic [5:0] RHO_TABLE [ROUNDS_T] = '{
        6'd1,  6'd3,  6'd6,  6'd10, 6'd15, 6'd21, 6'd28, 6'd36,
        6'd45, 6'd55, 6'd2,  6'd14, 6'd27, 6'd41, 6'd56, 6'd8,
        6'd25, 6'd43, 6'd62, 6'd18, 6'd39, 6'd61, 6'd20, 6'd44
    };

endpackage

// File: rtl/inverse_rotate_datapath_if.sv
// Slice-serial request/stream bundle between a producer and the inverse rotate block.
interface inverse_rotate_datapath_if;
    import keccak_pkg::*;

    logic             start;
    logic [LANES-1:0] inp;
    logic             ready;
    logic             outValid;
    logic [LANES-1:0] out;
    logic             done;

    modport master (
        output start, inp,
        input  ready, outValid, out, done
    );

    modport slave (
        input  start, inp,
        output ready, outValid, out, done
    );
endinterface

// File: rtl/lane_shifter.sv
// 64-bit lane register: hold, serial shift-in from the top, or circular right rotate.
module lane_shifter
    import keccak_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  shift_op_t         op,
    input  logic              ser_in,
    output logic [SLICES-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else begin
            case (op)
                SH_SHIFT_IN:  q <= {ser_in, q[SLICES-1:1]};
                SH_ROT_RIGHT: q <= {q[0], q[SLICES-1:1]};
                default:      q <= q;
            endcase
        end
    end

endmodule

// File: rtl/inverse_rotate_datapath.sv
// Inverse rho: buffers a slice-serial state, rotates each non-zero lane right by
// its rho offset one lane at a time, then streams the corrected slices out.
module inverse_rotate_datapath
    import keccak_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    inverse_rotate_datapath_if.slave    bus
);

    state_t           state;
    logic [5:0]       z;
    logic [5:0]       k;
    logic [4:0]       t;
    logic             ready_q;
    logic             out_valid_q;
    logic             done_q;

    logic [LANES-1:0] mem [SLICES];
    logic [LANES-1:0] rd_word;
    logic [LANES-1:0] wr_word;
    logic             mem_we;
    logic [4:0]       lane;
    logic [5:0]       rho;
    logic [SLICES-1:0] sr;
    shift_op_t        sh_op;
    logic             sh_clear;

    assign lane    = LANE_TABLE[t];
    assign rho     = RHO_TABLE[t];
    assign rd_word = mem[z];

    // Write-back only replaces the active lane's bit; the rest of the slice is preserved.
    always_comb begin
        wr_word  = rd_word;
        mem_we   = 1'b0;
        sh_op    = SH_HOLD;
        sh_clear = (state == ST_IDLE) && bus.start;
        case (state)
            ST_LOAD: begin
                mem_we  = 1'b1;
                wr_word = bus.inp;
            end
            ST_RD: begin
                sh_op = SH_SHIFT_IN;
            end
            ST_ROT: begin
                sh_op = SH_ROT_RIGHT;
            end
            ST_WR: begin
                mem_we        = 1'b1;
                wr_word[lane] = sr[0];
                sh_op         = SH_ROT_RIGHT;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[z] <= wr_word;
        end
    end

    lane_shifter u_lane_shifter (
        .clk    (clk),
        .rst    (rst),
        .clear  (sh_clear),
        .op     (sh_op),
        .ser_in (rd_word[lane]),
        .q      (sr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            z           <= '0;
            k           <= '0;
            t           <= '0;
            ready_q     <= 1'b1;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state   <= ST_LOAD;
                        z       <= '0;
                        ready_q <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    z <= z + 6'd1;
                    if (z == 6'd63) begin
                        state <= ST_RD;
                        t     <= '0;
                    end
                end
                ST_RD: begin
                    z <= z + 6'd1;
                    if (z == 6'd63) begin
                        state <= ST_ROT;
                        k     <= '0;
                    end
                end
                ST_ROT: begin
                    k <= k + 6'd1;
                    if (k == rho - 6'd1) begin
                        state <= ST_WR;
                        z     <= '0;
                    end
                end
                ST_WR: begin
                    z <= z + 6'd1;
                    if (z == 6'd63) begin
                        if (t == 5'(ROUNDS_T - 1)) begin
                            state       <= ST_OUT;
                            out_valid_q <= 1'b1;
                        end else begin
                            t     <= t + 5'd1;
                            state <= ST_RD;
                        end
                    end
                end
                ST_OUT: begin
                    z      <= z + 6'd1;
                    done_q <= (z == 6'd62);
                    if (z == 6'd63) begin
                        state       <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        ready_q     <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ready    = ready_q;
    assign bus.outValid = out_valid_q;
    assign bus.out      = rd_word;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_inverse_rotate_datapath.sv
// Directed bench for the inverse rho datapath: a scoreboard queue holds the
// expected output slices, compared as the DUT streams them out.
module tb_inverse_rotate_datapath;

    logic clk = 1'b0;
    logic rst = 1'b1;

    inverse_rotate_datapath_if bus ();

    inverse_rotate_datapath dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int          evaluated = 0;
    int          failures  = 0;
    int          c0;
    int          lane_of [24];
    int          rho_of  [24];
    logic [24:0] stim    [64];
    logic [24:0] orig    [64];
    logic [24:0] exp_q   [$];

    // Schedule derived from the (x,y) walk and triangular numbers rather than copied.
    task automatic buildTables();
        int x = 1;
        int y = 0;
        int nx;
        for (int t = 0; t < 24; t++) begin
            lane_of[t] = x + 5 * y;
            rho_of[t]  = ((t + 1) * (t + 2) / 2) % 64;
            nx = y;
            y  = (2 * x + 3 * y) % 5;
            x  = nx;
        end
    endtask

    task automatic expectEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        evaluated++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clearStim();
        for (int z = 0; z < 64; z++) stim[z] = '0;
    endtask

    task automatic pushInverseExpected();
        logic [24:0] w;
        for (int z = 0; z < 64; z++) begin
            w = stim[z];
            for (int t = 0; t < 24; t++) begin
                w[lane_of[t]] = stim[(z + rho_of[t]) % 64][lane_of[t]];
            end
            exp_q.push_back(w);
        end
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        expectEq("ready_before_start", 64'(bus.ready), 64'd1);
        bus.start = 1'b1;
        bus.inp   = '0;
        @(posedge clk);
        #1;
        c0        = cycle;
        bus.start = 1'b0;
        bus.inp   = stim[0];
        for (int z = 1; z < 64; z++) begin
            @(posedge clk);
            #1;
            bus.inp = stim[z];
        end
    endtask

    task automatic checkOutput(input bit pulses);
        int          n = 0;
        bit          seen = 1'b0;
        int          early_done = 0;
        logic [24:0] exp;
        for (int i = 0; i < 5000 && !seen; i++) begin
            @(negedge clk);
            n = cycle - c0;
            if (bus.outValid === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (bus.done !== 1'b0) early_done++;
                if (n == 70) expectEq("ready_while_busy", 64'(bus.ready), 64'd0);
                bus.start = pulses && (n == 100 || n == 128);
            end
        end
        bus.start = 1'b0;
        expectEq("first_valid_latency", seen ? 64'(n) : 64'hFFFF_FFFF, 64'd3816);
        expectEq("done_before_out", 64'(early_done), 64'd0);
        for (int z = 0; z < 64; z++) begin
            if (z > 0) @(negedge clk);
            expectEq($sformatf("out_valid[%0d]", z), 64'(bus.outValid), 64'd1);
            expectEq("scoreboard_nonempty", 64'(exp_q.size() != 0), 64'd1);
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 25'h0;
            expectEq($sformatf("slice[%0d]", z), 64'(bus.out), 64'(exp));
            expectEq($sformatf("done[%0d]", z), 64'(bus.done), 64'(z == 63));
            bus.start = pulses && (z == 5);
        end
        @(negedge clk);
        bus.start = 1'b0;
        expectEq("ready_after_out", 64'(bus.ready), 64'd1);
        expectEq("valid_after_out", 64'(bus.outValid), 64'd0);
        expectEq("done_after_out", 64'(bus.done), 64'd0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.inp   = '0;
        buildTables();
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        expectEq("reset_ready", 64'(bus.ready), 64'd1);
        expectEq("reset_valid", 64'(bus.outValid), 64'd0);
        expectEq("reset_done", 64'(bus.done), 64'd0);
        rst = 1'b1;

        $display("[TB] reset during LOAD at slice 10");
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int z = 0; z < 10; z++) begin
            bus.inp = 25'($urandom);
            @(posedge clk);
            #1;
        end
        #2 rst = 1'b0;
        #1;
        expectEq("abort_ready", 64'(bus.ready), 64'd1);
        expectEq("abort_valid", 64'(bus.outValid), 64'd0);
        expectEq("abort_done", 64'(bus.done), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] all-zero state after abort");
        clearStim();
        pushInverseExpected();
        applyStimulus();
        checkOutput(1'b0);

        $display("[TB] single bit lane 1 slice 0");
        clearStim();
        stim[0][1] = 1'b1;
        pushInverseExpected();
        applyStimulus();
        checkOutput(1'b0);

        $display("[TB] single bit lane 10 slice 3");
        clearStim();
        stim[3][10] = 1'b1;
        pushInverseExpected();
        applyStimulus();
        checkOutput(1'b0);

        $display("[TB] single bit lane 0 slice 5");
        clearStim();
        stim[5][0] = 1'b1;
        pushInverseExpected();
        applyStimulus();
        checkOutput(1'b0);

        $display("[TB] random state through forward rho then inverse");
        for (int z = 0; z < 64; z++) orig[z] = 25'($urandom);
        for (int z = 0; z < 64; z++) begin
            stim[z] = orig[z];
            for (int t = 0; t < 24; t++) begin
                stim[z][lane_of[t]] = orig[(z - rho_of[t] + 64) % 64][lane_of[t]];
            end
        end
        for (int z = 0; z < 64; z++) exp_q.push_back(orig[z]);
        applyStimulus();
        checkOutput(1'b0);

        $display("[TB] start pulses during RD, ROT and OUT");
        for (int z = 0; z < 64; z++) stim[z] = 25'($urandom);
        pushInverseExpected();
        applyStimulus();
        checkOutput(1'b1);

        expectEq("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
        $finish;
    end

endmodule
